// File: rtl/data_sram_pkg.sv
`default_nettype none
// =============================================================================
// Module  : data_sram_pkg
// Brief   : Shared encodings, response-entry type and alignment check for the
//           data-SRAM responder.
// Revision: 1.0 - initial release
// =============================================================================
package data_sram_pkg;

    localparam logic [1:0] c_SIZE_BYTE = 2'd0;
    localparam logic [1:0] c_SIZE_HALF = 2'd1;
    localparam logic [1:0] c_SIZE_WORD = 2'd2;

    typedef struct packed {
        logic [31:0] rdata;
        logic [2:0]  age;
    } resp_entry_t;

    // Reserved size 3 is treated as misaligned so it is flagged and suppressed.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] addr_lo);
        logic w_mis;
        case (size)
            c_SIZE_BYTE: w_mis = 1'b0;
            c_SIZE_HALF: w_mis = addr_lo[0];
            c_SIZE_WORD: w_mis = (addr_lo != 2'b00);
            default:     w_mis = 1'b1;
        endcase
        return w_mis;
    endfunction

endpackage
`default_nettype wire

// File: rtl/data_sram_resp_fifo.sv
`default_nettype none
// =============================================================================
// Module  : data_sram_resp_fifo
// Brief   : In-order response queue; each entry ages down from LATENCY and the
//           head is offered once its counter reaches zero.
// Revision: 1.0 - initial release
// =============================================================================
module data_sram_resp_fifo
    import data_sram_pkg::*;
#(
    parameter int DEPTH   = 2,
    parameter int LATENCY = 1,
    parameter int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [31:0]      i_push_rdata,
    input  logic             i_pop,
    output logic             o_head_ready,
    output logic [31:0]      o_head_rdata,
    output logic             o_full,
    output logic [CNT_W-1:0] o_count
);

    localparam int                 c_PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_PTR_W-1:0] c_LAST     = c_PTR_W'(DEPTH - 1);
    localparam logic [2:0]         c_AGE_INIT = 3'(LATENCY);
    localparam logic [CNT_W-1:0]   c_FULL_CNT = CNT_W'(DEPTH);

    resp_entry_t        r_entry [DEPTH];
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0]   r_count;
    resp_entry_t        w_head;

    function automatic logic [c_PTR_W-1:0] f_ptr_inc(input logic [c_PTR_W-1:0] ptr);
        return (ptr == c_LAST) ? '0 : ptr + 1'b1;
    endfunction

    assign w_head       = r_entry[r_rd_ptr];
    // Counter is sampled before this edge's decrement, so an age of 1 means it
    // hits zero in the current cycle.
    assign o_head_ready = (r_count != '0) && (w_head.age <= 3'd1);
    assign o_head_rdata = w_head.rdata;
    assign o_full       = (r_count == c_FULL_CNT);
    assign o_count      = r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= f_ptr_inc(r_wr_ptr);
            end
            if (i_pop) begin
                r_rd_ptr <= f_ptr_inc(r_rd_ptr);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload needs no reset: validity is carried entirely by r_count.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (r_entry[i].age != 3'd0) begin
                r_entry[i].age <= r_entry[i].age - 3'd1;
            end
        end
        if (i_push) begin
            r_entry[r_wr_ptr] <= '{rdata: i_push_rdata, age: c_AGE_INIT};
        end
    end

endmodule
`default_nettype wire

// File: rtl/data_sram_slave.sv
`default_nettype none
// =============================================================================
// Module  : data_sram_slave
// Brief   : Word-addressed data memory answering the CPU data-SRAM handshake
//           with byte-strobed stores and fixed-latency in-order responses.
// Revision: 1.0 - initial release
// =============================================================================
module data_sram_slave
    import data_sram_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 1,
    parameter int DEPTH   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata,
    output logic        err_misaligned
);

    localparam int c_WORDS = 1 << ADDR_W;
    localparam int c_CNT_W = $clog2(DEPTH + 1);

    logic [31:0]        r_mem [c_WORDS];
    logic [31:0]        r_last_rdata;
    logic               r_err;

    logic [ADDR_W-1:0]  w_word_idx;
    logic               w_misaligned;
    logic               w_accept;
    logic               w_store_en;
    logic [31:0]        w_load_word;
    logic [31:0]        w_push_rdata;
    logic               w_head_ready;
    logic [31:0]        w_head_rdata;
    logic               w_full;
    logic [c_CNT_W-1:0] w_count_unused;
    logic               w_addr_hi_unused;

    assign w_word_idx       = data_sram_addr[ADDR_W+1:2];
    assign w_addr_hi_unused = ^data_sram_addr[31:ADDR_W+2];
    assign w_misaligned     = is_misaligned(data_sram_size, data_sram_addr[1:0]);

    // A pop frees a slot in the same cycle, so a full queue can still accept.
    assign data_sram_addr_ok = ~w_full | w_head_ready;
    assign w_accept          = data_sram_req & data_sram_addr_ok;
    assign w_store_en        = w_accept & data_sram_wr & ~w_misaligned;

    assign w_load_word  = r_mem[w_word_idx];
    assign w_push_rdata = (data_sram_wr | w_misaligned) ? 32'd0 : w_load_word;

    always_ff @(posedge clk) begin
        if (w_store_en) begin
            for (int b = 0; b < 4; b++) begin
                if (data_sram_wstrb[b]) begin
                    r_mem[w_word_idx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
                end
            end
        end
    end

    data_sram_resp_fifo #(
        .DEPTH   (DEPTH),
        .LATENCY (LATENCY),
        .CNT_W   (c_CNT_W)
    ) u_resp_fifo (
        .clk          (clk),
        .reset        (reset),
        .i_push       (w_accept),
        .i_push_rdata (w_push_rdata),
        .i_pop        (w_head_ready),
        .o_head_ready (w_head_ready),
        .o_head_rdata (w_head_rdata),
        .o_full       (w_full),
        .o_count      (w_count_unused)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_rdata <= 32'd0;
            r_err        <= 1'b0;
        end else begin
            if (w_head_ready) begin
                r_last_rdata <= w_head_rdata;
            end
            if (w_accept & w_misaligned) begin
                r_err <= 1'b1;
            end
        end
    end

    // rdata follows the head during the pulse and holds the last answer otherwise.
    assign data_sram_data_ok = w_head_ready;
    assign data_sram_rdata   = w_head_ready ? w_head_rdata : r_last_rdata;
    assign err_misaligned    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_data_sram_slave.sv
`default_nettype none
// =============================================================================
// Module  : tb_data_sram_slave
// Brief   : Self-checking bench: four responders with different latencies share
//           one stimulus stream and are checked against a behavioural model.
// Revision: 1.0 - initial release
// =============================================================================
module tb_data_sram_slave;

    localparam int c_DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;

    logic        dok  [4];
    logic        aok  [4];
    logic        errf [4];
    logic [31:0] rd   [4];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    data_sram_slave #(.ADDR_W(10), .LATENCY(1), .DEPTH(c_DEPTH)) u_dut0 (
        .clk(clk), .reset(reset), .data_sram_req(req), .data_sram_wr(wr),
        .data_sram_size(size), .data_sram_wstrb(wstrb), .data_sram_addr(addr),
        .data_sram_wdata(wdata), .data_sram_addr_ok(aok[0]), .data_sram_data_ok(dok[0]),
        .data_sram_rdata(rd[0]), .err_misaligned(errf[0]));
    data_sram_slave #(.ADDR_W(10), .LATENCY(3), .DEPTH(c_DEPTH)) u_dut1 (
        .clk(clk), .reset(reset), .data_sram_req(req), .data_sram_wr(wr),
        .data_sram_size(size), .data_sram_wstrb(wstrb), .data_sram_addr(addr),
        .data_sram_wdata(wdata), .data_sram_addr_ok(aok[1]), .data_sram_data_ok(dok[1]),
        .data_sram_rdata(rd[1]), .err_misaligned(errf[1]));
    data_sram_slave #(.ADDR_W(10), .LATENCY(2), .DEPTH(c_DEPTH)) u_dut2 (
        .clk(clk), .reset(reset), .data_sram_req(req), .data_sram_wr(wr),
        .data_sram_size(size), .data_sram_wstrb(wstrb), .data_sram_addr(addr),
        .data_sram_wdata(wdata), .data_sram_addr_ok(aok[2]), .data_sram_data_ok(dok[2]),
        .data_sram_rdata(rd[2]), .err_misaligned(errf[2]));
    data_sram_slave #(.ADDR_W(10), .LATENCY(4), .DEPTH(c_DEPTH)) u_dut3 (
        .clk(clk), .reset(reset), .data_sram_req(req), .data_sram_wr(wr),
        .data_sram_size(size), .data_sram_wstrb(wstrb), .data_sram_addr(addr),
        .data_sram_wdata(wdata), .data_sram_addr_ok(aok[3]), .data_sram_data_ok(dok[3]),
        .data_sram_rdata(rd[3]), .err_misaligned(errf[3]));

    function automatic int lat_of(input int k);
        case (k)
            0:       return 1;
            1:       return 3;
            2:       return 2;
            default: return 4;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int          inst;
        longint      due;
        logic [31:0] data;
        logic [3:0]  kn;
    } exp_t;

    exp_t        q[$];
    logic [31:0] mem_m [4][1024];
    logic [3:0]  kn_m  [4][1024];
    logic        err_m [4];
    longint      cyc = 0;

    function automatic logic misal(input logic [1:0] sz, input logic [1:0] lo);
        return (sz == 2'd1 && lo[0]) || (sz == 2'd2 && lo != 2'd0) || (sz == 2'd3);
    endfunction

    function automatic logic [31:0] lane_mask(input logic [3:0] kn);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{kn[b]}};
        return m;
    endfunction

    // Each negedge: check the cycle's outputs, then apply the coming edge.
    always @(negedge clk) begin : model
        int          head;
        int          cnt;
        int          w;
        logic        edok;
        logic        eaok;
        logic [31:0] m;
        exp_t        e;
        if (reset) begin
            q.delete();
            for (int k = 0; k < 4; k++) err_m[k] = 1'b0;
        end
        for (int k = 0; k < 4; k++) begin
            head = -1;
            cnt  = 0;
            for (int j = 0; j < q.size(); j++) begin
                if (q[j].inst == k) begin
                    if (head < 0) head = j;
                    cnt++;
                end
            end
            edok = (head >= 0) && (q[head].due == cyc);
            eaok = (cnt < c_DEPTH) || edok;
            chk($sformatf("data_ok[%0d]", k), 32'(dok[k]), 32'(edok));
            chk($sformatf("addr_ok[%0d]", k), 32'(aok[k]), 32'(eaok));
            chk($sformatf("err[%0d]", k), 32'(errf[k]), 32'(err_m[k]));
            if (edok) begin
                m = lane_mask(q[head].kn);
                if (dok[k] && m != 32'd0)
                    chk($sformatf("rdata[%0d]", k), rd[k] & m, q[head].data & m);
                q.delete(head);
            end
            if (!reset && req && eaok) begin
                w      = int'(addr[11:2]);
                e.inst = k;
                e.due  = cyc + longint'(lat_of(k));
                e.data = 32'd0;
                e.kn   = 4'hF;
                if (misal(size, addr[1:0])) begin
                    err_m[k] = 1'b1;
                end else if (wr) begin
                    for (int b = 0; b < 4; b++) begin
                        if (wstrb[b]) begin
                            mem_m[k][w][8*b +: 8] = wdata[8*b +: 8];
                            kn_m[k][w][b]         = 1'b1;
                        end
                    end
                end else begin
                    e.data = mem_m[k][w];
                    e.kn   = kn_m[k][w];
                end
                q.push_back(e);
            end
        end
        cyc++;
    end

    // ---------------- stimulus ----------------
    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vt[13];

    function automatic vec_t mk(input logic w, input logic [1:0] s, input logic [3:0] st,
                                input logic [31:0] a, input logic [31:0] d, input logic [31:0] x);
        vec_t v;
        v.wr = w; v.size = s; v.wstrb = st; v.addr = a; v.wdata = d; v.exp = x;
        return v;
    endfunction

    task automatic drive(input logic r, input logic w, input logic [1:0] s,
                         input logic [3:0] st, input logic [31:0] a, input logic [31:0] d);
        req = r; wr = w; size = s; wstrb = st; addr = a; wdata = d;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin : stim
        logic        seen;
        int          npulse;
        logic        thr_aok [4];
        logic [31:0] thr_rd  [3];
        int          thr_cyc [3];
        logic [31:0] thr_addr [4];

        for (int k = 0; k < 4; k++)
            for (int w = 0; w < 1024; w++) kn_m[k][w] = 4'h0;

        vt[0]  = mk(1'b1, 2'd2, 4'hF, 32'h10,   32'hDEADBEEF, 32'h0);
        vt[1]  = mk(1'b0, 2'd2, 4'hF, 32'h10,   32'h0,        32'hDEADBEEF);
        vt[2]  = mk(1'b1, 2'd2, 4'hF, 32'h20,   32'h11223344, 32'h0);
        vt[3]  = mk(1'b1, 2'd0, 4'h4, 32'h22,   32'h00AA0000, 32'h0);
        vt[4]  = mk(1'b0, 2'd2, 4'hF, 32'h20,   32'h0,        32'h11AA3344);
        vt[5]  = mk(1'b1, 2'd2, 4'hF, 32'h22,   32'hFFFFFFFF, 32'h0);
        vt[6]  = mk(1'b0, 2'd2, 4'hF, 32'h20,   32'h0,        32'h11AA3344);
        vt[7]  = mk(1'b0, 2'd1, 4'hF, 32'h21,   32'h0,        32'h0);
        vt[8]  = mk(1'b1, 2'd2, 4'hF, 32'h30,   32'h01020304, 32'h0);
        vt[9]  = mk(1'b1, 2'd1, 4'hC, 32'h32,   32'hBEEF0000, 32'h0);
        vt[10] = mk(1'b0, 2'd2, 4'hF, 32'h30,   32'h0,        32'hBEEF0304);
        vt[11] = mk(1'b0, 2'd2, 4'hF, 32'h1010, 32'h0,        32'hDEADBEEF);
        vt[12] = mk(1'b0, 2'd3, 4'hF, 32'h10,   32'h0,        32'h0);

        reset = 1'b1;
        drive(1'b0, 1'b0, 2'd2, 4'h0, 32'h0, 32'h0);
        idle(3);
        reset = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rst_data_ok[%0d]", k), 32'(dok[k]), 32'd0);
            chk($sformatf("rst_rdata[%0d]", k), rd[k], 32'd0);
            chk($sformatf("rst_err[%0d]", k), 32'(errf[k]), 32'd0);
            chk($sformatf("rst_addr_ok[%0d]", k), 32'(aok[k]), 32'd1);
        end

        // Table: one isolated request at a time, all queues drained in between.
        for (int i = 0; i < 13; i++) begin
            @(posedge clk); #1;
            drive(1'b1, vt[i].wr, vt[i].size, vt[i].wstrb, vt[i].addr, vt[i].wdata);
            @(posedge clk); #1;
            req  = 1'b0;
            seen = 1'b0;
            for (int n = 0; n < 10 && !seen; n++) begin
                @(negedge clk);
                if (dok[0]) begin
                    seen = 1'b1;
                    chk($sformatf("vec%0d_rdata", i), rd[0], vt[i].exp);
                end
            end
            chk($sformatf("vec%0d_data_ok_seen", i), 32'(seen), 32'd1);
            idle(6);
        end
        chk("err_sticky", 32'(errf[0]), 32'd1);

        // Store then load to the same word on consecutive cycles.
        drive(1'b1, 1'b1, 2'd2, 4'hF, 32'h40, 32'hCAFEF00D);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 2'd2, 4'hF, 32'h40, 32'h0);
        @(negedge clk);
        chk("b2b_store_ok", 32'(dok[0]), 32'd1);
        chk("b2b_store_rdata", rd[0], 32'd0);
        @(posedge clk); #1;
        req = 1'b0;
        @(negedge clk);
        chk("b2b_load_ok", 32'(dok[0]), 32'd1);
        chk("b2b_load_rdata", rd[0], 32'hCAFEF00D);
        idle(8);

        // Throttling on the LATENCY=3 / DEPTH=2 instance.
        thr_addr = '{32'h10, 32'h20, 32'h30, 32'h30};
        thr_aok  = '{1'b1, 1'b1, 1'b0, 1'b1};
        thr_rd   = '{32'hDEADBEEF, 32'h11AA3344, 32'hBEEF0304};
        thr_cyc  = '{3, 4, 6};
        npulse   = 0;
        for (int i = 0; i < 12; i++) begin
            if (i < 4) drive(1'b1, 1'b0, 2'd2, 4'hF, thr_addr[i], 32'h0);
            else       req = 1'b0;
            @(negedge clk);
            if (i < 4) chk($sformatf("thr_addr_ok_c%0d", i), 32'(aok[1]), 32'(thr_aok[i]));
            if (dok[1]) begin
                if (npulse < 3) begin
                    chk($sformatf("thr_rdata%0d", npulse), rd[1], thr_rd[npulse]);
                    chk($sformatf("thr_cycle%0d", npulse), 32'(i), 32'(thr_cyc[npulse]));
                end
                npulse++;
            end
            @(posedge clk); #1;
        end
        chk("thr_pulses", 32'(npulse), 32'd3);
        idle(4);

        // Full plus pop: LATENCY=2 / DEPTH=2 sustains one accept per cycle.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, 2'd2, 4'hF, 32'h10, 32'h0);
            @(negedge clk);
            chk($sformatf("fp_addr_ok_c%0d", i), 32'(aok[2]), 32'd1);
            @(posedge clk); #1;
        end
        req = 1'b0;
        idle(8);

        // Reset in the middle of a LATENCY=4 load.
        drive(1'b1, 1'b0, 2'd2, 4'hF, 32'h10, 32'h0);
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk); #3;
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_data_ok", 32'(dok[3]), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_mid_addr_ok", 32'(aok[3]), 32'd1);
        chk("rst_mid_err", 32'(errf[3]), 32'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("rst_mid_no_pulse%0d", i), 32'(dok[3]), 32'd0);
        end
        @(posedge clk); #1;

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 9) < 6) ? 2'd2 :
                  ($urandom_range(0, 3) == 0) ? 2'd3 : 2'($urandom_range(0, 1)),
                  4'($urandom_range(0, 15)), $urandom & 32'h0000_303F, $urandom);
            @(posedge clk); #1;
        end
        req = 1'b0;
        idle(12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
